// File: rtl/banked_mem_responder_pkg.sv
// Shared defaults and address field positions for the banked memory responder.
// Address layout: [0] byte select, then bank index, then row index, then
// ignored high bits that alias onto the same storage.
package banked_mem_responder_pkg;

  localparam int unsigned DEF_DATA_W         = 16;
  localparam int unsigned DEF_ADDR_W         = 16;
  localparam int unsigned DEF_NUM_BANKS      = 4;
  localparam int unsigned DEF_WORDS_PER_BANK = 64;
  localparam int unsigned DEF_LATENCY        = 4;

  // Bank index starts right above the byte-select bit.
  localparam int unsigned BANK_LSB = 1;

  // Row index starts right above the bank index.
  function automatic int unsigned row_lsb(input int unsigned num_banks);
    return BANK_LSB + $clog2(num_banks);
  endfunction

endpackage

// File: rtl/banked_mem_responder_mem_bank.sv
// One storage bank of the responder: word array, busy down-counter,
// read-pending flag, captured read word and a zero-gated read output.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   en         request accepted into this bank at this edge
//   we         accepted request is a write (else read)
//   row        word index within the bank
//   wdata      write data
//   busy       bank cannot accept a request this cycle
//   done       read completion pulse (registered)
//   rdata      completed read word while done=1, else 0
module banked_mem_responder_mem_bank
  import banked_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned WORDS_PER_BANK = DEF_WORDS_PER_BANK,
  parameter int unsigned LATENCY        = DEF_LATENCY,
  localparam int unsigned ROW_W         = $clog2(WORDS_PER_BANK)
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned CNT_W = $clog2(LATENCY);

  logic [DATA_W-1:0] mem_q [WORDS_PER_BANK];
  logic [CNT_W-1:0]  cnt_q;
  logic              pend_q;
  logic [DATA_W-1:0] word_q;
  logic              done_q;
  logic [DATA_W-1:0] dout_q;

  // Counter is loaded with LATENCY-1 on accept; the completing read is
  // flagged on the edge that takes the counter from 1 to 0, so done lands
  // in the first cycle the bank is free again.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WORDS_PER_BANK); i++) begin
        mem_q[i] <= '0;
      end
      cnt_q  <= '0;
      pend_q <= 1'b0;
      word_q <= '0;
      done_q <= 1'b0;
      dout_q <= '0;
    end else begin
      done_q <= 1'b0;
      dout_q <= '0;
      if (en) begin
        cnt_q  <= CNT_W'(LATENCY - 1);
        pend_q <= ~we;
        if (we) begin
          mem_q[row] <= wdata;
        end else begin
          word_q <= mem_q[row];
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if ((cnt_q == CNT_W'(1)) && pend_q) begin
          done_q <= 1'b1;
          dout_q <= word_q;
          pend_q <= 1'b0;
        end
      end
    end
  end

  assign busy  = (cnt_q != '0);
  assign done  = done_q;
  assign rdata = dout_q;

endmodule

// File: rtl/banked_mem_responder.sv
// Memory-side responder: decodes byte addresses onto interleaved banks,
// accepts at most one legal request per cycle, flags illegal requests and
// stalls requests whose bank is still busy.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   rd, wr     read / write request (exactly one for a legal request)
//   addr       byte address, bit 0 must be 0
//   data_in    write data
//   data_out   read data while done=1, else 0
//   done       read completion pulse
//   stall      legal request held off because its bank is busy
//   busy       per-bank busy flags
//   err        illegal request this cycle (never accepted)
module banked_mem_responder
  import banked_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned NUM_BANKS      = DEF_NUM_BANKS,
  parameter int unsigned WORDS_PER_BANK = DEF_WORDS_PER_BANK,
  parameter int unsigned LATENCY        = DEF_LATENCY
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 done,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int unsigned BANK_W  = $clog2(NUM_BANKS);
  localparam int unsigned ROW_W   = $clog2(WORDS_PER_BANK);
  localparam int unsigned ROW_LSB = row_lsb(NUM_BANKS);

  logic [BANK_W-1:0]    bank_c;
  logic [ROW_W-1:0]     row_c;
  logic                 legal_c;
  logic                 accept_c;
  logic [NUM_BANKS-1:0] bank_en_c;
  logic [NUM_BANKS-1:0] bank_done;
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
  logic                 unused_addr;

  // Decode and request classification; err wins over stall by construction
  // because an illegal request is never "legal".
  always_comb begin
    bank_c   = addr[BANK_LSB +: BANK_W];
    row_c    = addr[ROW_LSB +: ROW_W];
    err      = (rd & wr) | ((rd | wr) & addr[0]);
    legal_c  = (rd ^ wr) & ~addr[0];
    stall    = legal_c & busy[bank_c];
    accept_c = legal_c & ~busy[bank_c] & ~rst;
    bank_en_c = '0;
    bank_en_c[bank_c] = accept_c;
  end

  // High address bits alias onto the same storage.
  assign unused_addr = ^addr;

  for (genvar i = 0; i < int'(NUM_BANKS); i++) begin : g_bank
    banked_mem_responder_mem_bank #(
      .DATA_W         (DATA_W),
      .WORDS_PER_BANK (WORDS_PER_BANK),
      .LATENCY        (LATENCY)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .en    (bank_en_c[i]),
      .we    (wr),
      .row   (row_c),
      .wdata (data_in),
      .busy  (busy[i]),
      .done  (bank_done[i]),
      .rdata (bank_rdata[i])
    );
  end

  // Only one bank can complete per cycle, so a plain OR merges the gated outputs.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < int'(NUM_BANKS); i++) begin
      data_out = data_out | bank_rdata[i];
    end
  end

  assign done = |bank_done;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Bench for banked_mem_responder: directed scenarios followed by random
// traffic, every cycle compared against a word-array / issue-time model.
module tb_banked_mem_responder;

  localparam int unsigned DATA_W         = 16;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned NUM_BANKS      = 4;
  localparam int unsigned WORDS_PER_BANK = 64;
  localparam int unsigned LATENCY        = 4;
  localparam int unsigned NWORDS         = NUM_BANKS * WORDS_PER_BANK;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rd;
  logic                 wr;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    data_in;
  logic [DATA_W-1:0]    data_out;
  logic                 done;
  logic                 stall;
  logic [NUM_BANKS-1:0] busy;
  logic                 err;

  always #5 clk = ~clk;

  banked_mem_responder #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .NUM_BANKS      (NUM_BANKS),
    .WORDS_PER_BANK (WORDS_PER_BANK),
    .LATENCY        (LATENCY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: flat word storage, cycle at which each bank frees up, and the
  // read result due in each future cycle.
  logic [DATA_W-1:0] mem_m [NWORDS];
  int                free_at [NUM_BANKS];
  logic [DATA_W-1:0] pend_m [int];
  logic              last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NWORDS); i++) mem_m[i] = '0;
    for (int i = 0; i < int'(NUM_BANKS); i++) free_at[i] = 0;
    pend_m.delete();
  endtask

  // Compare one cycle at the falling edge, then advance the model across
  // the following rising edge.
  task automatic tick();
    int                   widx;
    int                   b;
    logic                 s_rst, s_rd, s_wr;
    logic [DATA_W-1:0]    s_data;
    logic [NUM_BANKS-1:0] exp_busy;
    logic                 exp_err, exp_legal, exp_stall, exp_done, accept;
    logic [DATA_W-1:0]    exp_data;
    @(negedge clk);
    s_rst  = rst;
    s_rd   = rd;
    s_wr   = wr;
    s_data = data_in;
    widx   = int'(addr >> 1) % int'(NWORDS);
    b      = widx % int'(NUM_BANKS);
    for (int i = 0; i < int'(NUM_BANKS); i++) exp_busy[i] = (cyc < free_at[i]);
    exp_err   = (s_rd && s_wr) || ((s_rd || s_wr) && addr[0]);
    exp_legal = (s_rd != s_wr) && !addr[0];
    exp_stall = exp_legal && exp_busy[b];
    exp_done  = pend_m.exists(cyc);
    exp_data  = exp_done ? pend_m[cyc] : '0;
    check("err",      32'(err),      32'(exp_err));
    check("stall",    32'(stall),    32'(exp_stall));
    check("busy",     32'(busy),     32'(exp_busy));
    check("done",     32'(done),     32'(exp_done));
    check("data_out", 32'(data_out), 32'(exp_data));
    last_stall = exp_stall;
    accept     = exp_legal && !exp_busy[b] && !s_rst;
    @(posedge clk);
    if (exp_done) pend_m.delete(cyc);
    if (s_rst) begin
      model_reset();
    end else if (accept) begin
      if (s_wr) mem_m[widx] = s_data;
      else pend_m[cyc + int'(LATENCY)] = mem_m[widx];
      free_at[b] = cyc + int'(LATENCY);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    repeat (n) tick();
  endtask

  // Present a request and hold it while the bank stalls it.
  task automatic issue(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    int waited;
    waited = 0;
    rd = r; wr = w; addr = a; data_in = d;
    tick();
    while (last_stall && waited < int'(4 * LATENCY)) begin
      tick();
      waited++;
    end
  endtask

  initial begin
    int sel;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    last_stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    tick();                       // outputs quiet while reset held
    rst = 1'b0;

    // Write then read back bank 2.
    issue(1'b0, 1'b1, 16'h0004, 16'hBEEF);
    idle(3);
    issue(1'b1, 1'b0, 16'h0004, 16'h0000);
    idle(5);

    // Fill four banks, then read them back to back.
    issue(1'b0, 1'b1, 16'h0000, 16'h0001);
    issue(1'b0, 1'b1, 16'h0002, 16'h0002);
    issue(1'b0, 1'b1, 16'h0004, 16'h0003);
    issue(1'b0, 1'b1, 16'h0006, 16'h0004);
    idle(4);
    issue(1'b1, 1'b0, 16'h0000, 16'h0000);
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    issue(1'b1, 1'b0, 16'h0004, 16'h0000);
    issue(1'b1, 1'b0, 16'h0006, 16'h0000);
    idle(5);

    // Same-bank reads: second one stalls until the bank frees.
    issue(1'b1, 1'b0, 16'h0008, 16'h0000);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(5);

    // Illegal requests.
    rd = 1'b1; wr = 1'b1; addr = 16'h0002; data_in = 16'h5555;
    tick();
    rd = 1'b1; wr = 1'b0; addr = 16'h0003;
    tick();
    idle(5);

    // Reset while a read is in flight.
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    idle(5);

    // High address bits alias onto the same word.
    issue(1'b0, 1'b1, 16'h0202, 16'h1234);
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    idle(5);

    // Random traffic; stalled requests are held unchanged.
    repeat (600) begin
      if (!last_stall) begin
        sel     = int'($urandom_range(0, 15));
        rd      = (sel <= 6) || (sel == 12);
        wr      = (sel >= 7 && sel <= 12);
        addr    = 16'($urandom) & 16'h021F;
        if ($urandom_range(0, 7) != 0) addr[0] = 1'b0;
        data_in = 16'($urandom);
        rst     = ($urandom_range(0, 63) == 0);
      end else begin
        rst = 1'b0;
      end
      tick();
    end
    rst = 1'b0;
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
